// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller.
// One word per line; loads hit with zero wait, misses refill from backing memory.
module dcache_ctrl #(
  parameter int SET_WIDTH  = 6,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_re,
  input  logic                  cpu_we,
  input  logic                  cpu_byteop,
  input  logic [31:0]           cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  stall,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic                  mem_byte,
  output logic [31:0]           mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [1:0]            state_dbg
);

  localparam int NSETS = 1 << SET_WIDTH;
  localparam int TAG_W = 32 - SET_WIDTH - 2;

  typedef enum logic [1:0] {IDLE, FILL, WRITE, WDONE} state_t;

  state_t state_q, state_d;

  logic [NSETS-1:0]      valid_q;
  logic [TAG_W-1:0]      tag_q  [NSETS];
  logic [DATA_WIDTH-1:0] data_q [NSETS];

  logic [SET_WIDTH-1:0]  idx;
  logic [TAG_W-1:0]      tag;
  logic [4:0]            lane_sh;
  logic                  hit;
  logic [DATA_WIDTH-1:0] line;
  logic                  fill_we;
  logic                  store_upd;

  assign idx       = cpu_addr[SET_WIDTH+1:2];
  assign tag       = cpu_addr[31:SET_WIDTH+2];
  // Big-endian lanes: offset 0 is the most significant byte.
  assign lane_sh   = {~cpu_addr[1:0], 3'b000};
  assign line      = data_q[idx];
  assign hit       = valid_q[idx] && (tag_q[idx] == tag);
  assign fill_we   = (state_q == FILL) && mem_ack;
  assign store_upd = (state_q == WRITE) && mem_ack && hit;
  assign state_dbg = state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      if (fill_we) valid_q[idx] <= 1'b1;
    end
  end

  // Tag and data arrays carry no reset; valid bits alone qualify them.
  always_ff @(posedge clk) begin
    if (fill_we) begin
      tag_q[idx]  <= tag;
      data_q[idx] <= mem_rdata;
    end else if (store_upd) begin
      if (cpu_byteop) data_q[idx][lane_sh +: 8] <= cpu_wdata[7:0];
      else            data_q[idx] <= cpu_wdata;
    end
  end

  always_comb begin
    state_d   = state_q;
    cpu_rdata = '0;
    stall     = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_byte  = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (!rst) begin
      case (state_q)
        IDLE: begin
          if (cpu_we) begin
            stall   = 1'b1;
            state_d = WRITE;
          end else if (cpu_re) begin
            if (hit) begin
              if (cpu_byteop) cpu_rdata = {{(DATA_WIDTH-8){1'b0}}, line[lane_sh +: 8]};
              else            cpu_rdata = line;
            end else begin
              stall   = 1'b1;
              state_d = FILL;
            end
          end
        end
        FILL: begin
          stall    = 1'b1;
          mem_req  = 1'b1;
          mem_addr = {cpu_addr[31:2], 2'b00};
          if (mem_ack) state_d = IDLE;
        end
        WRITE: begin
          stall     = 1'b1;
          mem_req   = 1'b1;
          mem_we    = 1'b1;
          mem_byte  = cpu_byteop;
          mem_addr  = cpu_addr;
          mem_wdata = cpu_wdata;
          if (mem_ack) state_d = WDONE;
        end
        WDONE: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Bench for dcache_ctrl: directed scenarios plus randomized loads/stores checked
// against a word-addressed memory model and a per-index tag/valid model.
module tb_dcache_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_re, cpu_we, cpu_byteop;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        stall, mem_req, mem_we, mem_byte;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ack;
  logic [1:0]  state_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mem_m [int unsigned];
  bit          cv [64];
  logic [23:0] ct [64];

  dcache_ctrl #(.SET_WIDTH(6), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .cpu_re(cpu_re), .cpu_we(cpu_we), .cpu_byteop(cpu_byteop),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .stall(stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_byte(mem_byte), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    int unsigned key = a >> 2;
    if (!mem_m.exists(key)) mem_m[key] = $urandom;
    return mem_m[key];
  endfunction

  function automatic bit model_hit(input logic [31:0] a);
    return cv[a[7:2]] && (ct[a[7:2]] == a[31:8]);
  endfunction

  function automatic logic [31:0] exp_load(input logic [31:0] a, input bit byteop);
    logic [31:0] w = mem_word(a);
    int sh = 8 * (3 - int'(a[1:0]));
    if (byteop) return (w >> sh) & 32'hff;
    return w;
  endfunction

  task automatic do_load(input logic [31:0] a, input bit byteop, input int lat, input string nm);
    bit miss = !model_hit(a);
    logic [31:0] exp = exp_load(a, byteop);
    @(posedge clk); #1;
    cpu_re = 1; cpu_we = 0; cpu_byteop = byteop; cpu_addr = a; cpu_wdata = $urandom;
    @(negedge clk);
    n_checks++;
    if (!miss) begin
      if (stall !== 0 || mem_req !== 0 || cpu_rdata !== exp) begin
        n_fail++;
        $display("FAIL %s hit: stall=%b mem_req=%b rdata=%h, required stall=0 mem_req=0 rdata=%h",
                 nm, stall, mem_req, cpu_rdata, exp);
      end
    end else begin
      if (stall !== 1 || mem_req !== 0) begin
        n_fail++;
        $display("FAIL %s miss_detect: stall=%b mem_req=%b, required stall=1 mem_req=0", nm, stall, mem_req);
      end
      for (int k = 1; k <= lat + 1; k++) begin
        @(posedge clk); #1;
        if (k == lat + 1) begin mem_ack = 1; mem_rdata = mem_word(a); end
        @(negedge clk);
        n_checks++;
        if (stall !== 1 || mem_req !== 1 || mem_we !== 0 || mem_addr !== {a[31:2], 2'b00}) begin
          n_fail++;
          $display("FAIL %s fill_cycle%0d: stall=%b req=%b we=%b addr=%h, required 1 1 0 addr=%h",
                   nm, k, stall, mem_req, mem_we, mem_addr, {a[31:2], 2'b00});
        end
      end
      @(posedge clk); #1;
      mem_ack = 0; mem_rdata = $urandom;
      @(negedge clk);
      n_checks++;
      if (stall !== 0 || mem_req !== 0 || cpu_rdata !== exp) begin
        n_fail++;
        $display("FAIL %s retry: stall=%b mem_req=%b rdata=%h, required stall=0 mem_req=0 rdata=%h",
                 nm, stall, mem_req, cpu_rdata, exp);
      end
      cv[a[7:2]] = 1; ct[a[7:2]] = a[31:8];
    end
    @(posedge clk); #1;
    cpu_re = 0;
  endtask

  task automatic do_store(input logic [31:0] a, input bit byteop, input logic [31:0] wd,
                          input int lat, input bit also_re, input string nm);
    logic [31:0] w;
    int sh;
    @(posedge clk); #1;
    cpu_we = 1; cpu_re = also_re; cpu_byteop = byteop; cpu_addr = a; cpu_wdata = wd;
    @(negedge clk);
    n_checks++;
    if (stall !== 1 || mem_req !== 0) begin
      n_fail++;
      $display("FAIL %s store_accept: stall=%b mem_req=%b, required stall=1 mem_req=0", nm, stall, mem_req);
    end
    for (int k = 1; k <= lat + 1; k++) begin
      @(posedge clk); #1;
      if (k == lat + 1) mem_ack = 1;
      @(negedge clk);
      n_checks++;
      if (stall !== 1 || mem_req !== 1 || mem_we !== 1 || mem_byte !== byteop ||
          mem_addr !== a || mem_wdata !== wd) begin
        n_fail++;
        $display("FAIL %s write_cycle%0d: stall=%b req=%b we=%b byte=%b addr=%h wdata=%h, required 1 1 1 %b %h %h",
                 nm, k, stall, mem_req, mem_we, mem_byte, mem_addr, mem_wdata, byteop, a, wd);
      end
    end
    @(posedge clk); #1;
    mem_ack = 0;
    @(negedge clk);
    n_checks++;
    if (stall !== 0 || mem_req !== 0) begin
      n_fail++;
      $display("FAIL %s wdone: stall=%b mem_req=%b, required stall=0 mem_req=0", nm, stall, mem_req);
    end
    w = mem_word(a);
    if (byteop) begin
      sh = 8 * (3 - int'(a[1:0]));
      w = (w & ~(32'hff << sh)) | ({24'h0, wd[7:0]} << sh);
    end else begin
      w = wd;
    end
    mem_m[a >> 2] = w;
    @(posedge clk); #1;
    cpu_we = 0; cpu_re = 0;
  endtask

  task automatic test_reset;
    rst = 1; cpu_re = 1; cpu_we = 1; cpu_byteop = 0; cpu_addr = 32'h0001_0000;
    cpu_wdata = 32'h1234_5678; mem_ack = 0; mem_rdata = 0;
    @(negedge clk);
    n_checks++;
    if (stall !== 0 || mem_req !== 0 || mem_we !== 0 || mem_byte !== 0 ||
        mem_addr !== 0 || mem_wdata !== 0 || cpu_rdata !== 0) begin
      n_fail++;
      $display("FAIL reset_outputs: stall=%b req=%b we=%b byte=%b addr=%h wdata=%h rdata=%h, required all zero",
               stall, mem_req, mem_we, mem_byte, mem_addr, mem_wdata, cpu_rdata);
    end
    @(posedge clk); #1;
    rst = 0; cpu_re = 0; cpu_we = 0;
    for (int i = 0; i < 64; i++) cv[i] = 0;
  endtask

  task automatic test_directed;
    mem_m[32'h0001_0000 >> 2] = 32'h1122_3344;
    do_load(32'h0001_0000, 0, 3, "cold_load");
    do_load(32'h0001_0000, 0, 0, "repeat_hit");
    do_load(32'h0001_0002, 1, 0, "byte_hit");
    do_store(32'h0001_0001, 1, 32'h0000_00AA, 2, 0, "store_hit");
    do_load(32'h0001_0000, 0, 0, "after_store_hit");
    do_store(32'h0001_0100, 0, 32'hDEAD_BEEF, 1, 0, "store_miss");
    do_load(32'h0001_0000, 0, 0, "line_unchanged");
    mem_m[32'h0001_0100 >> 2] = 32'h5566_7788;
    do_load(32'h0001_0100, 0, 2, "conflict_fill");
    do_load(32'h0001_0000, 0, 1, "conflict_evicted");
  endtask

  task automatic test_priority_and_idle;
    do_store(32'h0001_0000, 0, 32'h1234_5678, 1, 1, "store_priority");
    do_load(32'h0001_0000, 0, 0, "after_priority");
    @(posedge clk); #1;
    mem_ack = 1; mem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    n_checks++;
    if (stall !== 0 || mem_req !== 0 || cpu_rdata !== 0) begin
      n_fail++;
      $display("FAIL idle_quiet: stall=%b mem_req=%b rdata=%h, required 0 0 00000000", stall, mem_req, cpu_rdata);
    end
    @(posedge clk); #1;
    mem_ack = 0;
    do_load(32'h0001_0000, 0, 0, "after_stray_ack");
  endtask

  task automatic test_reset_mid_fill;
    @(posedge clk); #1;
    cpu_re = 1; cpu_we = 0; cpu_byteop = 0; cpu_addr = 32'h0002_0000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1;
    #1;
    n_checks++;
    if (stall !== 0 || mem_req !== 0 || mem_addr !== 0) begin
      n_fail++;
      $display("FAIL reset_mid_fill: stall=%b mem_req=%b addr=%h, required 0 0 00000000", stall, mem_req, mem_addr);
    end
    @(posedge clk); #1;
    rst = 0; cpu_re = 0; mem_ack = 1; mem_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    n_checks++;
    if (stall !== 0 || mem_req !== 0) begin
      n_fail++;
      $display("FAIL late_ack: stall=%b mem_req=%b, required 0 0", stall, mem_req);
    end
    @(posedge clk); #1;
    mem_ack = 0;
    for (int i = 0; i < 64; i++) cv[i] = 0;
    do_load(32'h0002_0000, 0, 1, "after_reset_miss");
    do_load(32'h0001_0000, 0, 0, "after_reset_old_line");
  endtask

  task automatic test_random;
    logic [31:0] a;
    bit byteop;
    for (int n = 0; n < 80; n++) begin
      byteop = 1'($urandom_range(0, 1));
      a = (32'h100 + $urandom_range(0, 2)) << 8;
      a = a | ($urandom_range(0, 3) << 2);
      if (byteop) a = a | $urandom_range(0, 3);
      if ($urandom_range(0, 9) < 6)
        do_load(a, byteop, $urandom_range(0, 3), "rand_load");
      else
        do_store(a, byteop, $urandom, $urandom_range(0, 3), 1'($urandom_range(0, 1)), "rand_store");
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_priority_and_idle();
    test_reset_mid_fill();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
